// File: rtl/fp_align_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_align_shifter_pkg
// Description : Shared definitions for the FP adder exponent-alignment stage:
//               default field widths, field-extract helpers and the
//               alignment-stage state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_align_shifter_pkg;

    // Default IEEE single-precision field widths
    localparam int c_EW_DEFAULT = 8;
    localparam int c_MW_DEFAULT = 23;

    // Guard, round and sticky bits appended below the fraction
    localparam int c_GRS_W = 3;

    // Field-extract positions within a {sign, exp, frac} word
    function automatic int f_sign_idx(input int ew, input int mw);
        return ew + mw;
    endfunction

    function automatic int f_exp_hi(input int ew, input int mw);
        return ew + mw - 1;
    endfunction

    function automatic int f_exp_lo(input int mw);
        return mw;
    endfunction

    function automatic int f_frac_hi(input int mw);
        return mw - 1;
    endfunction

    // Alignment-stage state encoding
    typedef logic [1:0] state_t;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

endpackage : fp_align_shifter_pkg
`default_nettype wire

// File: rtl/fp_align_shifter_operand_swap.sv
`default_nettype none
// ============================================================================
// Module      : fp_operand_swap
// Description : Combinational operand compare/select. Decodes both operands,
//               picks the larger effective exponent as "big", and produces
//               the clamped alignment distance.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_operand_swap
    import fp_align_shifter_pkg::*;
#(
    parameter int EW = c_EW_DEFAULT,
    parameter int MW = c_MW_DEFAULT
) (
    input  logic [EW+MW:0] i_a,
    input  logic [EW+MW:0] i_b,
    output logic [EW-1:0]  o_exp_big,
    output logic           o_sign_big,
    output logic           o_sign_small,
    output logic [MW+3:0]  o_mant_big,
    output logic [MW+3:0]  o_mant_small,
    output logic [7:0]     o_dc,
    output logic           o_swapped
);

    localparam int c_SIGN    = f_sign_idx(EW, MW);
    localparam int c_EXP_HI  = f_exp_hi(EW, MW);
    localparam int c_EXP_LO  = f_exp_lo(MW);
    localparam int c_FRAC_HI = f_frac_hi(MW);
    localparam int c_MANT_W  = MW + 4;

    logic [EW-1:0] w_exp_a;
    logic [EW-1:0] w_exp_b;
    logic [EW-1:0] w_eff_a;
    logic [EW-1:0] w_eff_b;
    logic [MW+3:0] w_mant_a;
    logic [MW+3:0] w_mant_b;
    logic          w_a_big;
    logic [EW-1:0] w_eff_small;
    logic [EW:0]   w_d;
    logic [31:0]   w_d_wide;

    assign w_exp_a = i_a[c_EXP_HI:c_EXP_LO];
    assign w_exp_b = i_b[c_EXP_HI:c_EXP_LO];

    // Denormals (exp == 0) share the scale of exponent 1
    assign w_eff_a = (w_exp_a == '0) ? EW'(1) : w_exp_a;
    assign w_eff_b = (w_exp_b == '0) ? EW'(1) : w_exp_b;

    // Hidden bit is set for normal numbers only; G/R/S start cleared
    assign w_mant_a = {(w_exp_a != '0), i_a[c_FRAC_HI:0], 3'b000};
    assign w_mant_b = {(w_exp_b != '0), i_b[c_FRAC_HI:0], 3'b000};

    // Ties keep A as big so equal exponents never report a swap
    assign w_a_big = (w_eff_a >= w_eff_b);

    assign o_swapped    = ~w_a_big;
    assign o_exp_big    = w_a_big ? w_eff_a : w_eff_b;
    assign w_eff_small  = w_a_big ? w_eff_b : w_eff_a;
    assign o_sign_big   = w_a_big ? i_a[c_SIGN] : i_b[c_SIGN];
    assign o_sign_small = w_a_big ? i_b[c_SIGN] : i_a[c_SIGN];
    assign o_mant_big   = w_a_big ? w_mant_a : w_mant_b;
    assign o_mant_small = w_a_big ? w_mant_b : w_mant_a;

    // Distance never goes negative since big >= small
    assign w_d      = {1'b0, o_exp_big} - {1'b0, w_eff_small};
    assign w_d_wide = 32'(w_d);

    // Shifting past the full mantissa width leaves only sticky, so clamp
    assign o_dc = (w_d_wide >= 32'(c_MANT_W)) ? 8'(c_MANT_W) : w_d_wide[7:0];

endmodule : fp_operand_swap
`default_nettype wire

// File: rtl/fp_align_shifter.sv
`default_nettype none
// ============================================================================
// Module      : fp_align_shifter
// Description : FP adder exponent-alignment stage. Captures an operand pair,
//               drives an external down-counter and right-shifts the small
//               mantissa one bit per cycle with sticky until the counter
//               completes, then presents the aligned pair downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_align_shifter
    import fp_align_shifter_pkg::*;
#(
    parameter int EW = c_EW_DEFAULT,
    parameter int MW = c_MW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [EW+MW:0] a,
    input  logic [EW+MW:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [EW-1:0]  exp_out,
    output logic           sign_big,
    output logic           sign_small,
    output logic [MW+3:0]  mant_big,
    output logic [MW+3:0]  mant_small,
    output logic           swapped,
    output logic [7:0]     cnt_n,
    output logic           cnt_ld,
    output logic           cnt_en,
    input  logic           cnt_complete
);

    state_t        r_state;
    logic [EW-1:0] r_exp;
    logic          r_sign_big;
    logic          r_sign_small;
    logic [MW+3:0] r_mant_big;
    logic [MW+3:0] r_mant_small;
    logic          r_swapped;
    logic [7:0]    r_cnt_n;

    logic [EW-1:0] w_exp_big;
    logic          w_sign_big;
    logic          w_sign_small;
    logic [MW+3:0] w_mant_big;
    logic [MW+3:0] w_mant_small;
    logic [7:0]    w_dc;
    logic          w_swapped;

    fp_operand_swap #(
        .EW (EW),
        .MW (MW)
    ) u_swap (
        .i_a          (a),
        .i_b          (b),
        .o_exp_big    (w_exp_big),
        .o_sign_big   (w_sign_big),
        .o_sign_small (w_sign_small),
        .o_mant_big   (w_mant_big),
        .o_mant_small (w_mant_small),
        .o_dc         (w_dc),
        .o_swapped    (w_swapped)
    );

    // Capture, shift sequencing and handshake; reset aborts any pair in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_exp        <= '0;
            r_sign_big   <= 1'b0;
            r_sign_small <= 1'b0;
            r_mant_big   <= '0;
            r_mant_small <= '0;
            r_swapped    <= 1'b0;
            r_cnt_n      <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_exp        <= w_exp_big;
                        r_sign_big   <= w_sign_big;
                        r_sign_small <= w_sign_small;
                        r_mant_big   <= w_mant_big;
                        r_mant_small <= w_mant_small;
                        r_swapped    <= w_swapped;
                        r_cnt_n      <= w_dc;
                        r_state      <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    // Counter loads cnt_n-1 this edge; a zero shift skips it
                    r_state <= (r_cnt_n == 8'd0) ? c_ST_DONE : c_ST_SHIFT;
                end
                c_ST_SHIFT: begin
                    // The completing edge still shifts, giving exactly dc shifts
                    r_mant_small <= {1'b0, r_mant_small[MW+3:2],
                                     r_mant_small[1] | r_mant_small[0]};
                    if (cnt_complete) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Strobes and handshakes are pure state decodes so they can never overlap
    assign in_ready  = (r_state == c_ST_IDLE);
    assign cnt_ld    = (r_state == c_ST_LOAD);
    assign cnt_en    = (r_state == c_ST_SHIFT);
    assign out_valid = (r_state == c_ST_DONE);

    assign exp_out    = r_exp;
    assign sign_big   = r_sign_big;
    assign sign_small = r_sign_small;
    assign mant_big   = r_mant_big;
    assign mant_small = r_mant_small;
    assign swapped    = r_swapped;
    assign cnt_n      = r_cnt_n;

endmodule : fp_align_shifter
`default_nettype wire
